id_ex_alu_issue: RTL and testbench
==================================

Name: id_ex_alu_issue

Overview:
- ID/EX pipeline stage that drives the execute-stage ALU: opcode, operand A/B, shift amount and destination.
- Decodes the ID-stage instruction word and register-file read data into ALU control, then registers it into EX with stall and flush handling.
- Sits between the register file / hazard unit and the ALU.

Parameters:
- SHAMT_LUI, 16, fixed shift amount used to implement LUI as an SLL of the zero-extended immediate.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_instr  in  32  instruction word
- id_rs_data  in  32  register-file read of rs (instr[25:21])
- id_rt_data  in  32  register-file read of rt (instr[20:16])
- stall  in  1  hold EX registers
- flush  in  1  replace EX contents with a bubble
- ex_valid  out  1  EX holds a real instruction
- ex_alu_op  out  4  ALU opcode: ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, NOR 7, SLL 8, SLLV 9, SRL 10, SRLV 11
- ex_alu_a  out  32  ALU operand A
- ex_alu_b  out  32  ALU operand B
- ex_shamt  out  5  shift amount
- ex_dest  out  5  writeback register
- ex_wr_en  out  1  writeback enable
- ex_illegal  out  1  unsupported instruction flag

Behaviour:
- Clocking and reset: one clock; reset synchronous, active-high. On rst all outputs = 0.
- All outputs are registered, with 1-cycle latency from ID inputs to EX outputs.
- Priority each rising edge: rst > flush > stall > load.
- flush: load bubble (all outputs 0). Applies even if stall is also high.
- stall without flush: every output holds its value.
- load with id_valid=0: bubble.
- load with id_valid=1: decoded values; ex_valid=1.
- R-type (opcode 0), funct → op:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - For these: A=rs_data, B=rt_data, shamt=0.
  - 0x00 SLL and 0x02 SRL: A=0, B=rt_data, shamt=instr[10:6].
  - 0x04 SLLV and 0x06 SRLV: A=rs_data, B=rt_data, shamt=0. The ALU uses A as the shift amount.
  - dest=instr[15:11]; wr_en=1.
- I-type (dest=instr[20:16], wr_en=1, A=rs_data, shamt=0):
  - 0x08 ADDI → ADD, B=sign-extended imm.
  - 0x09 ADDIU → ADDU, B=sign-extended imm.
  - 0x0C ANDI → AND, 0x0D ORI → OR, 0x0E XORI → XOR; B=zero-extended imm.
  - 0x0F LUI → SLL, A=0, B=zero-extended imm, shamt=SHAMT_LUI.
- id_instr == 0 (canonical NOP): ex_valid=1, wr_en=0, op=SLL, all other outputs 0.
- wr_en is forced to 0 whenever dest == 0.
- Any other opcode or funct: ex_valid=1, ex_illegal=1, wr_en=0, op=ADD, A=B=shamt=dest=0.
- The block does not flag overflow; ADD/SUB overflow handling belongs downstream.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- When defined, three extra inputs are added:
  - fwd_wr (1)
  - fwd_reg (5)
  - fwd_data (32)
- At load, if fwd_wr=1, fwd_reg≠0 and fwd_reg equals instr rs (or rt), fwd_data replaces id_rs_data (or id_rt_data) before decode. rs and rt are checked independently, so both may be replaced.
- Under stall, outputs hold; forwarding does not update held operands.
- When undefined: the ports do not exist and operands come only from id_rs_data / id_rt_data.

Test Plan:
- rst high for 2 cycles, then ADD r3,r1,r2 (0x00221820) with rs=5, rt=7 → all outputs 0 during reset; next cycle ex_alu_op=0, A=5, B=7, dest=3, wr_en=1, ex_valid=1.
- ADDI r4,r1,-1 (0x2024FFFF), rs=10 → op=0, B=0xFFFFFFFF, dest=4. ORI with imm 0x8000 → op=5, B=0x00008000.
- LUI r5,0x1234 (0x3C051234) → op=8, A=0, B=0x00001234, shamt=16, dest=5. SLL r2,r1,4 (0x00011100) → op=8, shamt=4, dest=2, A=0.
- Load SUB, then stall=1 for 3 cycles while id_instr changes → outputs frozen at the SUB values. flush=1 together with stall=1 → next edge all outputs 0.
- Opcode 0x23 (LW) → ex_illegal=1, wr_en=0, ex_valid=1. Instr 0 → ex_valid=1, wr_en=0. ADD r0,r1,r2 → wr_en=0.
- ID_EX_FORWARD_EN defined: fwd_wr=1, fwd_reg=1, fwd_data=0xDEAD, ADD r3,r1,r1 with rs_data=5 → A=B=0xDEAD. Same with fwd_reg=0 → A=B=5.

Source files
------------

// File: rtl/id_ex_alu_issue.sv
//------------------------------------------------------------------------------
// Module   : id_ex_alu_issue
// Brief    : ID/EX stage register that decodes an instruction into ALU controls.
//            Optional macro ID_EX_FORWARD_EN adds an operand bypass at load.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_alu_issue #(
  parameter int SHAMT_LUI = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        stall,
  input  logic        flush,
`ifdef ID_EX_FORWARD_EN
  input  logic        fwd_wr,
  input  logic [4:0]  fwd_reg,
  input  logic [31:0] fwd_data,
`endif
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_alu_b,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_dest,
  output logic        ex_wr_en,
  output logic        ex_illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SLLV = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRLV = 4'd11;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [4:0] LUI_SHAMT = 5'(SHAMT_LUI);

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_sx;
  logic [31:0] w_imm_zx;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  assign w_opcode = id_instr[31:26];
  assign w_rs     = id_instr[25:21];
  assign w_rt     = id_instr[20:16];
  assign w_rd     = id_instr[15:11];
  assign w_sh     = id_instr[10:6];
  assign w_funct  = id_instr[5:0];
  assign w_imm_sx = {{16{id_instr[15]}}, id_instr[15:0]};
  assign w_imm_zx = {16'h0000, id_instr[15:0]};

`ifdef ID_EX_FORWARD_EN
  // rs and rt are bypassed independently; register 0 is never forwarded.
  assign w_rs_val = (fwd_wr && (fwd_reg != 5'd0) && (fwd_reg == w_rs)) ? fwd_data : id_rs_data;
  assign w_rt_val = (fwd_wr && (fwd_reg != 5'd0) && (fwd_reg == w_rt)) ? fwd_data : id_rt_data;
`else
  assign w_rs_val = id_rs_data;
  assign w_rt_val = id_rt_data;
`endif

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_sh;
  logic [4:0]  dec_dest;
  logic        dec_wr;
  logic        dec_ill;

  always_comb begin
    dec_op   = OP_ADD;
    dec_a    = 32'd0;
    dec_b    = 32'd0;
    dec_sh   = 5'd0;
    dec_dest = 5'd0;
    dec_wr   = 1'b0;
    dec_ill  = 1'b0;
    if (id_instr == 32'd0) begin
      dec_op = OP_SLL;
    end else begin
      case (w_opcode)
        OPC_RTYPE: begin
          dec_a    = w_rs_val;
          dec_b    = w_rt_val;
          dec_dest = w_rd;
          dec_wr   = 1'b1;
          case (w_funct)
            6'h20: dec_op = OP_ADD;
            6'h21: dec_op = OP_ADDU;
            6'h22: dec_op = OP_SUB;
            6'h23: dec_op = OP_SUBU;
            6'h24: dec_op = OP_AND;
            6'h25: dec_op = OP_OR;
            6'h26: dec_op = OP_XOR;
            6'h27: dec_op = OP_NOR;
            6'h00: begin dec_op = OP_SLL; dec_a = 32'd0; dec_sh = w_sh; end
            6'h02: begin dec_op = OP_SRL; dec_a = 32'd0; dec_sh = w_sh; end
            6'h04: dec_op = OP_SLLV;
            6'h06: dec_op = OP_SRLV;
            default: begin
              dec_op   = OP_ADD;
              dec_a    = 32'd0;
              dec_b    = 32'd0;
              dec_dest = 5'd0;
              dec_wr   = 1'b0;
              dec_ill  = 1'b1;
            end
          endcase
        end
        OPC_ADDI:  begin dec_op = OP_ADD;  dec_a = w_rs_val; dec_b = w_imm_sx; dec_dest = w_rt; dec_wr = 1'b1; end
        OPC_ADDIU: begin dec_op = OP_ADDU; dec_a = w_rs_val; dec_b = w_imm_sx; dec_dest = w_rt; dec_wr = 1'b1; end
        OPC_ANDI:  begin dec_op = OP_AND;  dec_a = w_rs_val; dec_b = w_imm_zx; dec_dest = w_rt; dec_wr = 1'b1; end
        OPC_ORI:   begin dec_op = OP_OR;   dec_a = w_rs_val; dec_b = w_imm_zx; dec_dest = w_rt; dec_wr = 1'b1; end
        OPC_XORI:  begin dec_op = OP_XOR;  dec_a = w_rs_val; dec_b = w_imm_zx; dec_dest = w_rt; dec_wr = 1'b1; end
        // LUI is issued as a fixed-distance left shift of the zero-extended immediate.
        OPC_LUI: begin
          dec_op   = OP_SLL;
          dec_b    = w_imm_zx;
          dec_sh   = LUI_SHAMT;
          dec_dest = w_rt;
          dec_wr   = 1'b1;
        end
        default: dec_ill = 1'b1;
      endcase
    end
    if (dec_dest == 5'd0) begin
      dec_wr = 1'b0;
    end
  end

  logic        valid_q, valid_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  sh_q, sh_d;
  logic [4:0]  dest_q, dest_d;
  logic        wr_q, wr_d;
  logic        ill_q, ill_d;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    dest_d  = dest_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d = 1'b0;
      op_d    = 4'd0;
      a_d     = 32'd0;
      b_d     = 32'd0;
      sh_d    = 5'd0;
      dest_d  = 5'd0;
      wr_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      a_d     = dec_a;
      b_d     = dec_b;
      sh_d    = dec_sh;
      dest_d  = dec_dest;
      wr_d    = dec_wr;
      ill_d   = dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sh_q    <= 5'd0;
      dest_q  <= 5'd0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      dest_q  <= dest_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_alu_op  = op_q;
  assign ex_alu_a   = a_q;
  assign ex_alu_b   = b_q;
  assign ex_shamt   = sh_q;
  assign ex_dest    = dest_q;
  assign ex_wr_en   = wr_q;
  assign ex_illegal = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_alu_issue.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_alu_issue
// Brief    : Directed self-checking bench for id_ex_alu_issue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_alu_issue;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
`ifdef ID_EX_FORWARD_EN
  logic        fwd_wr;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_dest;
  logic        ex_wr_en;
  logic        ex_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_alu_issue #(.SHAMT_LUI(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .stall      (stall),
    .flush      (flush),
`ifdef ID_EX_FORWARD_EN
    .fwd_wr     (fwd_wr),
    .fwd_reg    (fwd_reg),
    .fwd_data   (fwd_data),
`endif
    .ex_valid   (ex_valid),
    .ex_alu_op  (ex_alu_op),
    .ex_alu_a   (ex_alu_a),
    .ex_alu_b   (ex_alu_b),
    .ex_shamt   (ex_shamt),
    .ex_dest    (ex_dest),
    .ex_wr_en   (ex_wr_en),
    .ex_illegal (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic expect_ex(input string tag, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                           input logic [4:0] dest, input logic wr, input logic ill);
    check({tag, ".valid"}, 32'(ex_valid), 32'(v));
    check({tag, ".op"},    32'(ex_alu_op), 32'(op));
    check({tag, ".a"},     ex_alu_a, a);
    check({tag, ".b"},     ex_alu_b, b);
    check({tag, ".shamt"}, 32'(ex_shamt), 32'(sh));
    check({tag, ".dest"},  32'(ex_dest), 32'(dest));
    check({tag, ".wr"},    32'(ex_wr_en), 32'(wr));
    check({tag, ".ill"},   32'(ex_illegal), 32'(ill));
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    id_instr   = instr;
    id_rs_data = rs;
    id_rt_data = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
`ifdef ID_EX_FORWARD_EN
    fwd_wr = 1'b0; fwd_reg = 5'd0; fwd_data = 32'd0;
`endif
    issue(32'h00221820, 32'd5, 32'd7);
    expect_ex("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h00221820, 32'd5, 32'd7);
    expect_ex("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    issue(32'h00221820, 32'd5, 32'd7);
    expect_ex("add", 1, 0, 32'd5, 32'd7, 0, 3, 1, 0);
    issue(32'h2024FFFF, 32'd10, 32'd99);
    expect_ex("addi", 1, 0, 32'd10, 32'hFFFFFFFF, 0, 4, 1, 0);
    issue(32'h34268000, 32'h11, 32'd99);
    expect_ex("ori", 1, 5, 32'h11, 32'h00008000, 0, 6, 1, 0);
    issue(32'h3C051234, 32'h55, 32'h66);
    expect_ex("lui", 1, 8, 32'd0, 32'h00001234, 16, 5, 1, 0);
    issue(32'h00011100, 32'h55, 32'd7);
    expect_ex("sll", 1, 8, 32'd0, 32'd7, 4, 2, 1, 0);
    issue(32'h00221806, 32'd5, 32'd7);
    expect_ex("srlv", 1, 11, 32'd5, 32'd7, 0, 3, 1, 0);

    issue(32'h00221822, 32'd5, 32'd7);
    expect_ex("sub", 1, 2, 32'd5, 32'd7, 0, 3, 1, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(32'h3C0A0F0F + 32'(i), 32'hAA + 32'(i), 32'hBB);
      expect_ex("stall", 1, 2, 32'd5, 32'd7, 0, 3, 1, 0);
    end
    flush = 1'b1;
    issue(32'h00221820, 32'd1, 32'd2);
    expect_ex("flush", 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b0; flush = 1'b0;

    issue(32'h8C220000, 32'd5, 32'd7);
    expect_ex("lw", 1, 0, 0, 0, 0, 0, 0, 1);
    issue(32'h00221801, 32'd5, 32'd7);
    expect_ex("badfn", 1, 0, 0, 0, 0, 0, 0, 1);
    issue(32'h00000000, 32'd5, 32'd7);
    expect_ex("nop", 1, 8, 0, 0, 0, 0, 0, 0);
    issue(32'h00220020, 32'd5, 32'd7);
    expect_ex("add_r0", 1, 0, 32'd5, 32'd7, 0, 0, 0, 0);
    id_valid = 1'b0;
    issue(32'h00221820, 32'd5, 32'd7);
    expect_ex("bubble", 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 1'b1;

`ifdef ID_EX_FORWARD_EN
    fwd_wr = 1'b1; fwd_reg = 5'd1; fwd_data = 32'h0000DEAD;
    issue(32'h00211820, 32'd5, 32'd5);
    expect_ex("fwd", 1, 0, 32'h0000DEAD, 32'h0000DEAD, 0, 3, 1, 0);
    fwd_reg = 5'd0;
    issue(32'h00211820, 32'd5, 32'd5);
    expect_ex("fwd_r0", 1, 0, 32'd5, 32'd5, 0, 3, 1, 0);
    fwd_wr = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
